sme_feeder: RTL

Hardware host-side driver for the SME string-matching engine. It buffers one string (up to 32 chars) and one pattern (up to 8 chars) written by a host, streams them over the SME `chardata`/`isstring`/`ispattern` interface, waits for SME `valid`, and returns the captured match result. It sits between a host/CPU register port and the `SME` instance, replacing the file-driven stimulus with synthesizable sequencing.

---
 rtl/sme_feeder.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sme_feeder.sv
// sme_feeder: host-side driver for the SME string-matching engine.
// Buffers one string and one pattern written by a host, streams them to SME
// on chardata/isstring/ispattern, waits for SME valid and returns the result.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   wr_en_i, wr_sel_i, wr_data_i  append a char to string (sel=0) / pattern (sel=1)
//   clr_i                         empty both buffers, clear wr_full
//   cmd_str_i, cmd_pat_i          start string stream / pattern stream + result wait
//   busy_o, wr_full_o             status
//   res_valid_o, res_match_o,     result strobe and captured result
//   res_index_o, res_timeout_o
//   chardata_o, isstring_o,       stream to SME
//   ispattern_o
//   valid_i, match_i,             result from SME
//   match_index_i
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | accepts writes, clr and commands
// SEND_STR | streaming string buffer, isstring high
// SEND_PAT | streaming pattern buffer, ispattern high
// WAIT_VLD | waiting for SME valid or timeout
module sme_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_en_i,
  input  logic       wr_sel_i,
  input  logic [7:0] wr_data_i,
  input  logic       clr_i,
  input  logic       cmd_str_i,
  input  logic       cmd_pat_i,
  output logic       busy_o,
  output logic       wr_full_o,
  output logic       res_valid_o,
  output logic       res_match_o,
  output logic [4:0] res_index_o,
  output logic       res_timeout_o,
  output logic [7:0] chardata_o,
  output logic       isstring_o,
  output logic       ispattern_o,
  input  logic       valid_i,
  input  logic       match_i,
  input  logic [4:0] match_index_i
);

  localparam int LW  = $clog2(STR_MAX + 1);
  localparam int PW  = $clog2(PAT_MAX + 1);
  localparam int SAW = $clog2(STR_MAX);
  localparam int PAW = $clog2(PAT_MAX);
  localparam int IW  = (LW > PW) ? LW : PW;
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [LW-1:0] STR_MAX_L = LW'(STR_MAX);
  localparam logic [PW-1:0] PAT_MAX_L = PW'(PAT_MAX);
  localparam logic [TW-1:0] TIMEOUT_L = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SEND_STR = 2'd1,
    S_SEND_PAT = 2'd2,
    S_WAIT_VLD = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [LW-1:0]  str_len_q, str_len_d;
  logic [PW-1:0]  pat_len_q, pat_len_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [TW-1:0]  wait_q, wait_d;
  logic           wr_full_q, wr_full_d;

  logic           busy_q, busy_d;
  logic           isstring_q, isstring_d;
  logic           ispattern_q, ispattern_d;
  logic [7:0]     chardata_q, chardata_d;
  logic           res_valid_q, res_valid_d;
  logic           res_match_q, res_match_d;
  logic [4:0]     res_index_q, res_index_d;
  logic           res_timeout_q, res_timeout_d;

  logic [7:0]     str_mem [STR_MAX];
  logic [7:0]     pat_mem [PAT_MAX];

  logic idle, do_clr, do_str, do_pat, do_wr;
  logic str_wr, pat_wr, str_last, pat_last, got_valid, timed_out;

  // Command decode in IDLE, priority clr > cmd_str > cmd_pat > wr_en.
  // A command on an empty buffer still wins priority but does nothing.
  assign idle      = (state_q == S_IDLE);
  assign do_clr    = idle & clr_i;
  assign do_str    = idle & ~clr_i & cmd_str_i & (str_len_q != '0);
  assign do_pat    = idle & ~clr_i & ~cmd_str_i & cmd_pat_i & (pat_len_q != '0);
  assign do_wr     = idle & ~clr_i & ~cmd_str_i & ~cmd_pat_i & wr_en_i;
  assign str_wr    = do_wr & ~wr_sel_i & (str_len_q < STR_MAX_L);
  assign pat_wr    = do_wr &  wr_sel_i & (pat_len_q < PAT_MAX_L);
  assign str_last  = (idx_q == IW'(str_len_q));
  assign pat_last  = (idx_q == IW'(pat_len_q));
  assign got_valid = (state_q == S_WAIT_VLD) & valid_i;
  assign timed_out = (state_q == S_WAIT_VLD) & ~valid_i & (wait_q == TIMEOUT_L);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      str_len_q     <= '0;
      pat_len_q     <= '0;
      idx_q         <= '0;
      wait_q        <= '0;
      wr_full_q     <= 1'b0;
      busy_q        <= 1'b0;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
      chardata_q    <= 8'h00;
      res_valid_q   <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= 5'd0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      str_len_q     <= str_len_d;
      pat_len_q     <= pat_len_d;
      idx_q         <= idx_d;
      wait_q        <= wait_d;
      wr_full_q     <= wr_full_d;
      busy_q        <= busy_d;
      isstring_q    <= isstring_d;
      ispattern_q   <= ispattern_d;
      chardata_q    <= chardata_d;
      res_valid_q   <= res_valid_d;
      res_match_q   <= res_match_d;
      res_index_q   <= res_index_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  // Buffer storage needs no reset: only entries below the length are ever read.
  always_ff @(posedge clk_i) begin
    if (str_wr) str_mem[str_len_q[SAW-1:0]] <= wr_data_i;
    if (pat_wr) pat_mem[pat_len_q[PAW-1:0]] <= wr_data_i;
  end

  always_comb begin
    state_d   = state_q;
    str_len_d = str_len_q;
    pat_len_d = pat_len_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    wr_full_d = wr_full_q;
    unique case (state_q)
      S_IDLE: begin
        if (do_clr) begin
          str_len_d = '0;
          pat_len_d = '0;
          wr_full_d = 1'b0;
        end else if (do_str) begin
          state_d = S_SEND_STR;
          idx_d   = IW'(1);
        end else if (do_pat) begin
          state_d = S_SEND_PAT;
          idx_d   = IW'(1);
        end else if (do_wr) begin
          if (str_wr)      str_len_d = str_len_q + 1'b1;
          else if (pat_wr) pat_len_d = pat_len_q + 1'b1;
          else             wr_full_d = 1'b1;
        end
      end
      S_SEND_STR: begin
        if (str_last) state_d = S_IDLE;
        else          idx_d   = idx_q + 1'b1;
      end
      S_SEND_PAT: begin
        if (pat_last) begin
          state_d = S_WAIT_VLD;
          wait_d  = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_WAIT_VLD: begin
        if (got_valid || timed_out) state_d = S_IDLE;
        else                        wait_d  = wait_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; char 0 is launched on the
  // accepting edge so the stream starts in the first busy cycle.
  always_comb begin
    busy_d        = 1'b0;
    isstring_d    = 1'b0;
    ispattern_d   = 1'b0;
    chardata_d    = 8'h00;
    res_valid_d   = 1'b0;
    res_match_d   = res_match_q;
    res_index_d   = res_index_q;
    res_timeout_d = res_timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (do_str) begin
          busy_d     = 1'b1;
          isstring_d = 1'b1;
          chardata_d = str_mem[0];
        end else if (do_pat) begin
          busy_d        = 1'b1;
          ispattern_d   = 1'b1;
          chardata_d    = pat_mem[0];
          res_match_d   = 1'b0;
          res_index_d   = 5'd0;
          res_timeout_d = 1'b0;
        end
      end
      S_SEND_STR: begin
        if (!str_last) begin
          busy_d     = 1'b1;
          isstring_d = 1'b1;
          chardata_d = str_mem[idx_q[SAW-1:0]];
        end
      end
      S_SEND_PAT: begin
        busy_d = 1'b1;
        if (!pat_last) begin
          ispattern_d = 1'b1;
          chardata_d  = pat_mem[idx_q[PAW-1:0]];
        end
      end
      S_WAIT_VLD: begin
        if (got_valid) begin
          res_valid_d   = 1'b1;
          res_match_d   = match_i;
          res_index_d   = match_index_i;
          res_timeout_d = 1'b0;
        end else if (timed_out) begin
          res_valid_d   = 1'b1;
          res_match_d   = 1'b0;
          res_index_d   = 5'd0;
          res_timeout_d = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy_o        = busy_q;
  assign wr_full_o     = wr_full_q;
  assign res_valid_o   = res_valid_q;
  assign res_match_o   = res_match_q;
  assign res_index_o   = res_index_q;
  assign res_timeout_o = res_timeout_q;
  assign chardata_o    = chardata_q;
  assign isstring_o    = isstring_q;
  assign ispattern_o   = ispattern_q;

endmodule
